// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the two-requester round-robin burst arbiter.
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_A = 2'b01,
        GRANT_B = 2'b10
    } arb_state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux2_rr_arbiter_mux.sv
// Plain two-input multiplexer: sel=0 passes a, sel=1 passes b.
module Mux_2x1 #(
    parameter int bitwidth = 32
) (
    input  logic [bitwidth-1:0] a,
    input  logic [bitwidth-1:0] b,
    input  logic                sel,
    output logic [bitwidth-1:0] y
);

    always_comb begin
        y = sel ? b : a;
    end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin burst arbiter driving a shared downstream port.
// Optional burst-length limit with timeout pulse enabled by `define ARB_TIMEOUT_EN.
module mux2_rr_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int BITWIDTH  = 32,
    parameter int MAX_BURST = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                a_valid,
    input  logic [BITWIDTH-1:0] a_data,
    input  logic                a_last,
    output logic                a_ready,
    input  logic                b_valid,
    input  logic [BITWIDTH-1:0] b_data,
    input  logic                b_last,
    output logic                b_ready,
    output logic                y_valid,
    output logic [BITWIDTH-1:0] y_data,
    output logic                y_last,
    input  logic                y_ready,
    output logic                sel,
    output logic                busy,
    output logic                timeout_err
);

    arb_state_t        state;
    logic              rr_ptr;     // requester that won the most recent arbitration
    logic [BITWIDTH:0] mux_y;
    logic              force_last;
    logic              xfer;

    Mux_2x1 #(.bitwidth(BITWIDTH + 1)) u_mux (
        .a   ({a_last, a_data}),
        .b   ({b_last, b_data}),
        .sel (sel),
        .y   (mux_y)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic [CNT_W-1:0] beat_cnt;

    assign force_last = (beat_cnt == CNT_W'(MAX_BURST - 1));
`else
    assign force_last  = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign y_data = mux_y[BITWIDTH-1:0];
    assign xfer   = y_valid & y_ready;

    // sel is registered alongside state, so the mux's last bit always belongs to the granted side
    always_comb begin
        y_valid = 1'b0;
        y_last  = 1'b0;
        a_ready = 1'b0;
        b_ready = 1'b0;
        case (state)
            GRANT_A: begin
                y_valid = a_valid;
                y_last  = mux_y[BITWIDTH] | force_last;
                a_ready = y_ready;
            end
            GRANT_B: begin
                y_valid = b_valid;
                y_last  = mux_y[BITWIDTH] | force_last;
                b_ready = y_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= SEL_B;
            sel    <= SEL_A;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (a_valid && (!b_valid || rr_ptr == SEL_B)) begin
                        state  <= GRANT_A;
                        rr_ptr <= SEL_A;
                        sel    <= SEL_A;
                        busy   <= 1'b1;
                    end else if (b_valid) begin
                        state  <= GRANT_B;
                        rr_ptr <= SEL_B;
                        sel    <= SEL_B;
                        busy   <= 1'b1;
                    end
                end
                GRANT_A, GRANT_B: begin
                    if (xfer && y_last) begin
                        state <= IDLE;
                        sel   <= SEL_A;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    sel   <= SEL_A;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= xfer && force_last;
            if (xfer && y_last) begin
                beat_cnt <= '0;
            end else if (xfer) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scoreboard bench for mux2_rr_arbiter; the forced-release case runs only with ARB_TIMEOUT_EN.
module tb_mux2_rr_arbiter;
    localparam int BW = 16;

    logic          clk;
    logic          rst_n;
    logic          a_valid, a_last, a_ready;
    logic [BW-1:0] a_data;
    logic          b_valid, b_last, b_ready;
    logic [BW-1:0] b_data;
    logic          y_valid, y_last, y_ready;
    logic [BW-1:0] y_data;
    logic          sel, busy, timeout_err;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    logic [BW:0]   a_src[$];
    logic [BW:0]   b_src[$];
    logic [BW+1:0] exp_q[$];   // {src, last, data}
    int            xfer_cyc[$];

    mux2_rr_arbiter #(.BITWIDTH(BW), .MAX_BURST(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_valid     (a_valid),
        .a_data      (a_data),
        .a_last      (a_last),
        .a_ready     (a_ready),
        .b_valid     (b_valid),
        .b_data      (b_data),
        .b_last      (b_last),
        .b_ready     (b_ready),
        .y_valid     (y_valid),
        .y_data      (y_data),
        .y_last      (y_last),
        .y_ready     (y_ready),
        .sel         (sel),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pa(input logic [BW-1:0] d, input logic l);
        a_src.push_back({l, d});
    endtask
    task automatic pb(input logic [BW-1:0] d, input logic l);
        b_src.push_back({l, d});
    endtask
    task automatic ex(input logic s, input logic [BW-1:0] d, input logic l);
        exp_q.push_back({s, l, d});
    endtask

    // Requester A driver: holds the head beat until it is accepted
    initial begin
        logic fire;
        a_valid = 1'b0; a_data = '0; a_last = 1'b0;
        forever begin
            @(negedge clk);
            fire = a_valid && a_ready && rst_n;
            @(posedge clk); #1;
            if (fire && a_src.size() > 0) void'(a_src.pop_front());
            if (a_src.size() > 0) begin
                a_valid = 1'b1; {a_last, a_data} = a_src[0];
            end else begin
                a_valid = 1'b0; a_last = 1'b0; a_data = '0;
            end
        end
    end

    initial begin
        logic fire;
        b_valid = 1'b0; b_data = '0; b_last = 1'b0;
        forever begin
            @(negedge clk);
            fire = b_valid && b_ready && rst_n;
            @(posedge clk); #1;
            if (fire && b_src.size() > 0) void'(b_src.pop_front());
            if (b_src.size() > 0) begin
                b_valid = 1'b1; {b_last, b_data} = b_src[0];
            end else begin
                b_valid = 1'b0; b_last = 1'b0; b_data = '0;
            end
        end
    end

    // Monitor: every downstream transfer is matched against the scoreboard
    always @(negedge clk) begin
        if (rst_n && y_valid && y_ready) begin
            xfer_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_xfer", {sel, y_last, y_data}, '0);
            end else begin
                chk("xfer", {sel, y_last, y_data}, exp_q.pop_front());
            end
        end
    end

    task automatic wait_drain(input string name);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && a_src.size() == 0 && b_src.size() == 0) break;
        end
        chk(name, 64'(exp_q.size() + a_src.size() + b_src.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        y_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_outputs", {busy, sel, y_valid, a_ready, b_ready, timeout_err}, 6'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_outputs", {busy, sel, y_valid, y_last, a_ready, b_ready, timeout_err}, 7'b0);

        // 1: both valid, A wins first with a 3-beat burst, then B after one bubble
        xfer_cyc.delete();
        y_ready = 1'b1;
        pa(16'hA000, 1'b0); pa(16'hA001, 1'b0); pa(16'hA002, 1'b1);
        pb(16'hB000, 1'b1);
        ex(1'b0, 16'hA000, 1'b0); ex(1'b0, 16'hA001, 1'b0); ex(1'b0, 16'hA002, 1'b1);
        ex(1'b1, 16'hB000, 1'b1);
        wait_drain("t1_drain");
        if (xfer_cyc.size() == 4) begin
            chk("t1_burst_back_to_back", 64'(xfer_cyc[1] - xfer_cyc[0]), 64'd1);
            chk("t1_idle_bubble", 64'(xfer_cyc[3] - xfer_cyc[2]), 64'd2);
        end else begin
            chk("t1_xfer_count", 64'(xfer_cyc.size()), 64'd4);
        end

        // 2: both valid with single-beat bursts -> strict alternation
        pa(16'hA100, 1'b1); pa(16'hA101, 1'b1); pa(16'hA102, 1'b1);
        pb(16'hB100, 1'b1); pb(16'hB101, 1'b1); pb(16'hB102, 1'b1);
        ex(1'b0, 16'hA100, 1'b1); ex(1'b1, 16'hB100, 1'b1);
        ex(1'b0, 16'hA101, 1'b1); ex(1'b1, 16'hB101, 1'b1);
        ex(1'b0, 16'hA102, 1'b1); ex(1'b1, 16'hB102, 1'b1);
        wait_drain("t2_drain");

        // 3: downstream stall during GRANT_A; B waits without ready
        y_ready = 1'b0;
        pa(16'hA200, 1'b0); pa(16'hA201, 1'b1);
        pb(16'hB200, 1'b1);
        ex(1'b0, 16'hA200, 1'b0); ex(1'b0, 16'hA201, 1'b1); ex(1'b1, 16'hB200, 1'b1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy) break;
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_stall", {busy, sel, y_valid, a_ready, b_ready}, 5'b10100);
        end
        @(posedge clk); #2;
        y_ready = 1'b1;
        wait_drain("t3_drain");

        // 4: reset on beat 2 of a 4-beat B burst, then A is granted first
        pb(16'hB300, 1'b0); pb(16'hB301, 1'b0); pb(16'hB302, 1'b0); pb(16'hB303, 1'b1);
        ex(1'b1, 16'hB300, 1'b0);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #2;
            if (b_src.size() == 3) break;
        end
        chk("t4_first_beat_sent", 64'(b_src.size()), 64'd3);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_immediate", {busy, sel, y_valid, b_ready}, 4'b0);
        @(posedge clk); #2;
        b_src.delete();
        pa(16'hA400, 1'b1);
        pb(16'hB300, 1'b0); pb(16'hB301, 1'b0); pb(16'hB302, 1'b0); pb(16'hB303, 1'b1);
        ex(1'b0, 16'hA400, 1'b1);
        ex(1'b1, 16'hB300, 1'b0); ex(1'b1, 16'hB301, 1'b0);
        ex(1'b1, 16'hB302, 1'b0); ex(1'b1, 16'hB303, 1'b1);
        @(posedge clk); #2;
        @(negedge clk);
        rst_n = 1'b1;
        wait_drain("t4_drain");

        // 5: only B, single-beat bursts -> one transfer every two cycles
        xfer_cyc.delete();
        pb(16'hB500, 1'b1); pb(16'hB501, 1'b1); pb(16'hB502, 1'b1);
        ex(1'b1, 16'hB500, 1'b1); ex(1'b1, 16'hB501, 1'b1); ex(1'b1, 16'hB502, 1'b1);
        wait_drain("t5_drain");
        if (xfer_cyc.size() == 3) begin
            chk("t5_gap1", 64'(xfer_cyc[1] - xfer_cyc[0]), 64'd2);
            chk("t5_gap2", 64'(xfer_cyc[2] - xfer_cyc[1]), 64'd2);
        end else begin
            chk("t5_xfer_count", 64'(xfer_cyc.size()), 64'd3);
        end

`ifdef ARB_TIMEOUT_EN
        // 6: A never ends its burst; release forced on beat 4
        pa(16'hA600, 1'b0); pa(16'hA601, 1'b0); pa(16'hA602, 1'b0);
        pa(16'hA603, 1'b0); pa(16'hA604, 1'b0); pa(16'hA605, 1'b1);
        ex(1'b0, 16'hA600, 1'b0); ex(1'b0, 16'hA601, 1'b0); ex(1'b0, 16'hA602, 1'b0);
        ex(1'b0, 16'hA603, 1'b1);
        ex(1'b0, 16'hA604, 1'b0); ex(1'b0, 16'hA605, 1'b1);
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #2;
            if (a_src.size() == 2) break;
        end
        @(negedge clk);
        chk("t6_timeout_pulse", {timeout_err, busy}, 2'b10);
        @(negedge clk);
        chk("t6_timeout_one_cycle", {timeout_err, busy}, 2'b01);
        wait_drain("t6_drain");
`else
        chk("no_timeout", {31'b0, timeout_err}, 32'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
